// File: rtl/prbs8_checker.sv
// Blind period meter and bit checker for the prbs8 serial stream: learns the
// repetition period from the first 8-bit window, then checks each bit against one period back.
module prbs8_checker (
   input  logic       clk,
   input  logic       reset,
   input  logic       rand1,
   output logic [8:0] period,
   output logic       period_valid,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic       timeout
);

   typedef enum logic [1:0] {FILL, ARM, MEASURE, LOCKED} state_t;

   state_t       state, state_nxt;
   logic [7:0]   win, ref_win;
   logic [255:0] hist;
   logic [2:0]   fill;
   logic [8:0]   cnt;
   logic [3:0]   consec;
   logic [7:0]   per_idx;
   logic         win_hit, cnt_full, miss, last_miss;

   // period 256 wraps to index 255 through the 8-bit subtract
   assign per_idx   = period[7:0] - 8'd1;
   assign miss      = rand1 != hist[per_idx];
   assign win_hit   = win == ref_win;
   assign cnt_full  = cnt == 9'd256;
   assign last_miss = miss && (consec == 4'd7);

   always_ff @(posedge clk) begin
      if (reset) state <= FILL;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (fill == 3'd7) state_nxt = ARM;
         ARM:     state_nxt = MEASURE;
         MEASURE: begin
            if (win_hit)       state_nxt = LOCKED;
            else if (cnt_full) state_nxt = ARM;
         end
         LOCKED:  if (last_miss) state_nxt = ARM;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win          <= '0;
         ref_win      <= '0;
         hist         <= '0;
         fill         <= '0;
         cnt          <= '0;
         consec       <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         err          <= 1'b0;
         err_cnt      <= '0;
         timeout      <= 1'b0;
      end else begin
         win     <= {win[6:0], rand1};
         hist    <= {hist[254:0], rand1};
         err     <= 1'b0;
         timeout <= 1'b0;
         case (state)
            FILL: fill <= fill + 3'd1;
            ARM: begin
               ref_win <= win;
               cnt     <= 9'd1;
            end
            MEASURE: begin
               // a match at cnt == 256 still counts as a lock
               if (win_hit) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  err_cnt      <= '0;
                  consec       <= '0;
               end else if (cnt_full) begin
                  timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            LOCKED: begin
               if (miss) begin
                  err    <= 1'b1;
                  consec <= consec + 4'd1;
                  if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                  if (consec == 4'd7)   period_valid <= 1'b0;
               end else begin
                  consec <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
